// File: rtl/write_interface.sv
// Write-side control for a single-clock FIFO: owns the write pointer, gates memory
// writes, and produces registered full / almost_full / fill_level plus sticky overflow.
module write_interface #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDR_WIDTH         = 5,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH:0]   read_addr,
    input  logic                  mem_read_en,
    output logic [ADDR_WIDTH:0]   write_addr,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LEVEL   = PW'(DEPTH - ALMOST_FULL_MARGIN);

    logic [PW-1:0] r_write_addr;
    logic [PW-1:0] r_fill_level;
    logic          r_full;
    logic          r_almost_full;
    logic          r_overflow;

    logic          w_accept;
    logic [PW-1:0] w_wp_nxt;
    logic [PW-1:0] w_rp_nxt;
    logic [PW-1:0] w_fill_nxt;

    // Gating uses the registered full, so a write coinciding with a pop at full is rejected.
    assign w_accept   = write_en & ~r_full & ~rst;
    assign w_wp_nxt   = r_write_addr + PW'(w_accept);
    assign w_rp_nxt   = read_addr + PW'(mem_read_en);
    assign w_fill_nxt = w_wp_nxt - w_rp_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_addr  <= '0;
            r_fill_level  <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_write_addr  <= w_wp_nxt;
            r_fill_level  <= w_fill_nxt;
            r_full        <= (w_fill_nxt == FULL_LEVEL);
            r_almost_full <= (w_fill_nxt >= AF_LEVEL);
            // Set term is OR-ed last, so a simultaneous set and clear leaves overflow set.
            r_overflow    <= (r_overflow & ~overflow_clr) | (write_en & r_full);
        end
    end

    assign write_addr     = r_write_addr;
    assign mem_write_en   = w_accept;
    assign mem_write_data = write_data;
    assign full           = r_full;
    assign almost_full    = r_almost_full;
    assign fill_level     = r_fill_level;
    assign overflow       = r_overflow;

endmodule
